softmax_engine: RTL

Sequential fixed-point softmax that serves the `start`/`busy`/`done` handshake issued by the training controller. It converts the FCL logits `fcl_output_data` into class probabilities for `cross_entropy_loss`. The block latches a logit vector on `start` and finds the maximum. It then computes base-2 approximated exponentials of the max-shifted logits and normalises them with a shared bit-serial divider. It pulses `done` with `output_data` held stable.

---
 rtl/softmax_engine.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/softmax_engine.sv
// Sequential fixed-point softmax: max search, base-2 exponentials of the max-shifted logits,
// then normalisation through one shared restoring divider.
module softmax_engine #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned FIXED_POINT_INDEX = 16,
  parameter int unsigned DIMENSION         = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] input_data_i  [DIMENSION],
  output logic signed [WIDTH-1:0] output_data_o [DIMENSION],
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned FPI  = FIXED_POINT_INDEX;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned IdxW = $clog2(DIMENSION + 1);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic signed [PW-1:0] Log2e =
      PW'($rtoi(1.4426950408889634 * (2.0 ** FPI) + 0.5));

  typedef enum logic [2:0] {StIdle, StFindMax, StExp, StDiv, StDone} state_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           idx_q;
  logic [BitW-1:0]           bit_q;
  logic signed [WIDTH-1:0]   x_q   [DIMENSION];
  logic signed [WIDTH-1:0]   max_q;
  logic signed [PW-1:0]      prod_q;
  logic [WIDTH-1:0]          exp_q [DIMENSION];
  logic [WIDTH-1:0]          sum_q;
  logic [WIDTH-1:0]          rem_q;
  logic [WIDTH-1:0]          quo_q;
  logic signed [WIDTH-1:0]   out_q [DIMENSION];

  logic                      idx_last, exp_drain, bit_last;
  logic signed [WIDTH-1:0]   diff;
  logic signed [PW-1:0]      prod_d, y_val, n_val;
  logic [PW-1:0]             neg_n;
  logic [WIDTH-1:0]          mant, exp_val;
  logic [PW-1:0]             dividend;
  logic [WIDTH-1:0]          rem_cur, lo_cur, rem_nxt, quo_nxt;
  logic [WIDTH:0]            trial;
  logic                      ge;

  assign idx_last  = (idx_q == IdxW'(DIMENSION - 1));
  assign exp_drain = (idx_q == IdxW'(DIMENSION));
  assign bit_last  = (bit_q == BitW'(WIDTH - 1));

  // Exponential: product registered one cycle, so EXP runs DIMENSION+1 cycles to drain.
  always_comb begin
    diff    = x_q[idx_q] - max_q;
    prod_d  = PW'(diff) * Log2e;
    y_val   = prod_q >>> FPI;
    n_val   = y_val >>> FPI;
    neg_n   = -n_val;
    mant    = WIDTH'({1'b1, y_val[FPI-1:0]});
    exp_val = (neg_n < PW'(WIDTH)) ? (mant >> neg_n[BitW-1:0]) : '0;
  end

  // One restoring-division step; the first step of each element seeds from exp_q directly.
  always_comb begin
    dividend = PW'(exp_q[idx_q]) << FPI;
    rem_cur  = (bit_q == '0) ? dividend[PW-1:WIDTH] : rem_q;
    lo_cur   = (bit_q == '0) ? dividend[WIDTH-1:0] : quo_q;
    trial    = {rem_cur, lo_cur[WIDTH-1]};
    ge       = (trial >= {1'b0, sum_q});
    rem_nxt  = ge ? WIDTH'(trial - {1'b0, sum_q}) : trial[WIDTH-1:0];
    quo_nxt  = {lo_cur[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StFindMax;
      StFindMax: if (idx_last) state_d = StExp;
      StExp:     if (exp_drain) state_d = StDiv;
      StDiv:     if (idx_last && bit_last) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign output_data_o = out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      bit_q   <= '0;
      max_q   <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      for (int i = 0; i < int'(DIMENSION); i++) begin
        x_q[i]   <= '0;
        exp_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q   <= input_data_i;
            idx_q <= '0;
            sum_q <= '0;
          end
        end
        StFindMax: begin
          if (idx_q == '0 || x_q[idx_q] > max_q) max_q <= x_q[idx_q];
          idx_q <= idx_last ? '0 : idx_q + IdxW'(1);
        end
        StExp: begin
          prod_q <= prod_d;
          if (idx_q != '0) begin
            exp_q[idx_q - IdxW'(1)] <= exp_val;
            sum_q                   <= sum_q + exp_val;
          end
          idx_q <= exp_drain ? '0 : idx_q + IdxW'(1);
          bit_q <= '0;
        end
        StDiv: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          bit_q <= bit_last ? '0 : bit_q + BitW'(1);
          if (bit_last) begin
            out_q[idx_q] <= quo_nxt;
            idx_q        <= idx_q + IdxW'(1);
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

endmodule
